// File: rtl/seq_div_unit.sv
// seq_div_unit: multi-cycle restoring divider (DIV/DIVU), remainder->HI, quotient->LO; ports clk, reset, start, isSigned, dividend, divisor -> busy, done, quotient, remainder, divByZero
module seq_div_unit #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         isSigned,
  input  logic [n-1:0] dividend,
  input  logic [n-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] quotient,
  output logic [n-1:0] remainder,
  output logic         divByZero
);
  localparam int cw = $clog2(n);
  localparam logic [1:0] st_idle = 2'd0;
  localparam logic [1:0] st_run  = 2'd1;
  localparam logic [1:0] st_done = 2'd2;
  localparam logic [cw-1:0] last = cw'(n - 1);
  logic [1:0]    state;
  logic [cw-1:0] cnt;
  logic [n-1:0]  pr, dq, dm, qr, qr_nx, pr_nx, a_mag, b_mag;
  logic [n:0]    sh, diff;
  logic          sq, sr, a_neg, b_neg;
  always_comb begin
    a_neg = isSigned & dividend[n-1];
    b_neg = isSigned & divisor[n-1];
    a_mag = a_neg ? -dividend : dividend;
    b_mag = b_neg ? -divisor : divisor;
    sh    = {pr, dq[n-1]};
    diff  = sh - {1'b0, dm};
    pr_nx = diff[n] ? sh[n-1:0] : diff[n-1:0];
    qr_nx = {qr[n-2:0], ~diff[n]};
  end
  // partial remainder stays below the divisor magnitude, so n bits hold it between iterations
  assign busy = state == st_run;
  assign done = state == st_done;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= st_idle;
      cnt       <= '0;
      pr        <= '0;
      dq        <= '0;
      dm        <= '0;
      qr        <= '0;
      sq        <= 1'b0;
      sr        <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      divByZero <= 1'b0;
    end else if (state == st_idle) begin
      if (start && divisor == '0) begin
        state     <= st_done;
        quotient  <= '1;
        remainder <= dividend;
        divByZero <= 1'b1;
      end else if (start) begin
        state <= st_run;
        dq    <= a_mag;
        dm    <= b_mag;
        sq    <= a_neg ^ b_neg;
        sr    <= a_neg;
        pr    <= '0;
        qr    <= '0;
        cnt   <= '0;
      end
    end else if (state == st_run) begin
      pr  <= pr_nx;
      dq  <= dq << 1;
      qr  <= qr_nx;
      cnt <= cnt + 1'b1;
      if (cnt == last) begin
        state     <= st_done;
        quotient  <= sq ? -qr_nx : qr_nx;
        remainder <= sr ? -pr_nx : pr_nx;
        divByZero <= 1'b0;
      end
    end else begin
      state <= st_idle;
    end
  end
endmodule

// File: tb/tb_seq_div_unit.sv
// tb_seq_div_unit: self-checking bench for seq_div_unit at n=8
module tb_seq_div_unit;
  logic       clk = 1'b0;
  logic       reset, start, isSigned;
  logic [7:0] dividend, divisor;
  logic       busy, done, divByZero;
  logic [7:0] quotient, remainder;
  int tests = 0;
  int fails = 0;
  typedef struct { logic s; logic [7:0] a, b, q, r; logic z; } vec_t;
  typedef struct { logic [7:0] q, r; logic z; } exp_t;
  vec_t tv[8];
  exp_t sb[$];
  exp_t mon_e;
  seq_div_unit #(.n(8)) dut (
    .clk(clk), .reset(reset), .start(start), .isSigned(isSigned),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .divByZero(divByZero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected no result pending");
      end else begin
        mon_e = sb.pop_front();
        chk("quotient", {24'd0, quotient}, {24'd0, mon_e.q});
        chk("remainder", {24'd0, remainder}, {24'd0, mon_e.r});
        chk("divByZero", {31'd0, divByZero}, {31'd0, mon_e.z});
      end
    end
  end
  task automatic do_div(input logic s, input logic [7:0] a, b, q, r, input logic z);
    int cyc, bc;
    @(negedge clk);
    isSigned = s; dividend = a; divisor = b; start = 1'b1;
    sb.push_back('{q, r, z});
    @(negedge clk);
    start = 1'b0;
    dividend = 8'($urandom);
    divisor = 8'($urandom);
    cyc = 1;
    bc = int'(busy);
    while (done !== 1'b1 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      bc += int'(busy);
    end
    chk("latency", cyc, z ? 1 : 9);
    chk("busy_cycles", bc, z ? 0 : 8);
    @(negedge clk);
    chk("done_pulse", {31'd0, done}, 0);
  endtask
  initial begin
    int cyc, qi, ri, sa, sb_i, nd;
    logic s;
    logic [7:0] a, b;
    tv[0] = '{1'b0, 8'd100, 8'd7,  8'd14,  8'd2,   1'b0};
    tv[1] = '{1'b1, 8'hF9,  8'h02, 8'hFD,  8'hFF,  1'b0};
    tv[2] = '{1'b1, 8'h07,  8'hFE, 8'hFD,  8'h01,  1'b0};
    tv[3] = '{1'b0, 8'h5A,  8'h00, 8'hFF,  8'h5A,  1'b1};
    tv[4] = '{1'b1, 8'h80,  8'hFF, 8'h80,  8'h00,  1'b0};
    tv[5] = '{1'b0, 8'hFF,  8'h01, 8'hFF,  8'h00,  1'b0};
    tv[6] = '{1'b0, 8'h80,  8'hFF, 8'h00,  8'h80,  1'b0};
    tv[7] = '{1'b1, 8'hA5,  8'h00, 8'hFF,  8'hA5,  1'b1};
    reset = 1'b1; start = 1'b0; isSigned = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_q", {24'd0, quotient}, 0);
    chk("rst_r", {24'd0, remainder}, 0);
    chk("rst_z", {31'd0, divByZero}, 0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) do_div(tv[i].s, tv[i].a, tv[i].b, tv[i].q, tv[i].r, tv[i].z);
    for (int i = 0; i < 16; i++) begin
      s = 1'($urandom_range(0, 1));
      a = 8'($urandom);
      b = 8'($urandom_range(1, 255));
      if (s) begin
        sa = $signed(a);
        sb_i = $signed(b);
        qi = sa / sb_i;
        ri = sa % sb_i;
      end else begin
        qi = int'(a) / int'(b);
        ri = int'(a) % int'(b);
      end
      do_div(s, a, b, 8'(qi), 8'(ri), 1'b0);
    end
    @(negedge clk);
    isSigned = 1'b0; dividend = 8'd100; divisor = 8'd7; start = 1'b1;
    sb.push_back('{8'd14, 8'd2, 1'b0});
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    dividend = 8'd50; divisor = 8'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("hs_busy_kept", {31'd0, busy}, 1);
    dividend = 8'd9; divisor = 8'd3; start = 1'b1;
    sb.push_back('{8'd3, 8'd0, 1'b0});
    cyc = 0;
    while (done !== 1'b1 && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    chk("hs_done_seen", {31'd0, done}, 1);
    @(negedge clk);
    chk("hs_idle_busy", {31'd0, busy}, 0);
    chk("hs_idle_done", {31'd0, done}, 0);
    @(negedge clk);
    chk("hs_restart", {31'd0, busy}, 1);
    chk("hs_hold_q", {24'd0, quotient}, 14);
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    chk("hs2_done_seen", {31'd0, done}, 1);
    @(negedge clk);
    isSigned = 1'b0; dividend = 8'd100; divisor = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_done", {31'd0, done}, 0);
    chk("arst_q", {24'd0, quotient}, 0);
    chk("arst_r", {24'd0, remainder}, 0);
    chk("arst_z", {31'd0, divByZero}, 0);
    @(negedge clk);
    reset = 1'b0;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      nd += int'(done);
    end
    chk("arst_no_done", nd, 0);
    do_div(1'b0, 8'd9, 8'd3, 8'd3, 8'd0, 1'b0);
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
